// File: rtl/gpio_irq.sv
// gpio_irq: memory-mapped GPIO bank with pad synchronisers, atomic set/clear/toggle
// and sticky per-pin rising/falling-edge interrupt flags (W1C).
module gpio_irq #(
   parameter logic [7:0]  GPIO_ADDRESS = 8'h00,
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       din,
   input  logic [7:0]       address,
   input  logic             w_en,
   input  logic             r_en,
   output logic [7:0]       dout,
   output logic [WIDTH-1:0] dir,
   output logic [WIDTH-1:0] port,
   output logic             irq,
   inout  wire  [WIDTH-1:0] pins
);

   localparam logic [7:0] A_DIR  = GPIO_ADDRESS;
   localparam logic [7:0] A_PORT = GPIO_ADDRESS + 8'd1;
   localparam logic [7:0] A_PINS = GPIO_ADDRESS + 8'd2;
   localparam logic [7:0] A_SET  = GPIO_ADDRESS + 8'd3;
   localparam logic [7:0] A_CLR  = GPIO_ADDRESS + 8'd4;
   localparam logic [7:0] A_TGL  = GPIO_ADDRESS + 8'd5;
   localparam logic [7:0] A_REN  = GPIO_ADDRESS + 8'd6;
   localparam logic [7:0] A_FEN  = GPIO_ADDRESS + 8'd7;
   localparam logic [7:0] A_FLAG = GPIO_ADDRESS + 8'd8;

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] rise_en;
   logic [WIDTH-1:0] fall_en;
   logic [WIDTH-1:0] flag;

   logic [WIDTH-1:0] din_w;
   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] w1c;
   logic [WIDTH-1:0] dir_nxt;
   logic [WIDTH-1:0] port_nxt;
   logic [WIDTH-1:0] rise_en_nxt;
   logic [WIDTH-1:0] fall_en_nxt;
   logic [WIDTH-1:0] flag_nxt;
   logic [7:0]       rd_data_c;

   // Pads: driven from the port latch only where configured as output
   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_pad
      assign pins[i] = dir[i] ? port[i] : 1'bz;
   end

   assign din_w = WIDTH'(din);
   assign sync  = sync_q[SYNC_STAGES-1];
   assign rise  = sync & ~prev_q;
   assign fall  = ~sync & prev_q;

   // Read mux; unmapped addresses and write-only registers return zero
   always_comb begin
      rd_data_c = 8'h00;
      case (address)
         A_DIR:   rd_data_c = 8'(dir);
         A_PORT:  rd_data_c = 8'(port);
         A_PINS:  rd_data_c = 8'(sync);
         A_REN:   rd_data_c = 8'(rise_en);
         A_FEN:   rd_data_c = 8'(fall_en);
         A_FLAG:  rd_data_c = 8'(flag);
         default: rd_data_c = 8'h00;
      endcase
   end

   // Register writes and flag update; an edge in the same cycle as W1C keeps the flag set
   always_comb begin
      dir_nxt     = dir;
      port_nxt    = port;
      rise_en_nxt = rise_en;
      fall_en_nxt = fall_en;
      w1c         = '0;
      if (w_en) begin
         case (address)
            A_DIR:   dir_nxt     = din_w;
            A_PORT:  port_nxt    = din_w;
            A_SET:   port_nxt    = port | din_w;
            A_CLR:   port_nxt    = port & ~din_w;
            A_TGL:   port_nxt    = port ^ din_w;
            A_REN:   rise_en_nxt = din_w;
            A_FEN:   fall_en_nxt = din_w;
            A_FLAG:  w1c         = din_w;
            default: ;
         endcase
      end
      flag_nxt = (flag & ~w1c) | (rise & rise_en) | (fall & fall_en);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         prev_q  <= '0;
         dir     <= '0;
         port    <= '0;
         rise_en <= '0;
         fall_en <= '0;
         flag    <= '0;
         dout    <= 8'h00;
         irq     <= 1'b0;
      end else begin
         sync_q[0] <= pins;
         for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         prev_q  <= sync;
         dir     <= dir_nxt;
         port    <= port_nxt;
         rise_en <= rise_en_nxt;
         fall_en <= fall_en_nxt;
         flag    <= flag_nxt;
         dout    <= r_en ? rd_data_c : 8'h00;
         // irq mirrors the flag register exactly, taken from the same next value
         irq     <= |flag_nxt;
      end
   end

endmodule

// File: tb/tb_gpio_irq.sv
// tb_gpio_irq: randomized scoreboard bench for gpio_irq against a cycle-level model,
// plus directed checks on a narrow instance placed at the top of the address space.
module tb_gpio_irq;

   localparam logic [7:0]  BASE  = 8'h20;
   localparam int unsigned S     = 2;
   localparam logic [7:0]  BASE2 = 8'hF7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main instance: 8 pins, 2-stage synchroniser
   logic       rst, w_en, r_en;
   logic [7:0] din, address;
   logic [7:0] dout, dir, port;
   logic       irq;
   wire  [7:0] pins;
   logic [7:0] pad_val;

   for (genvar i = 0; i < 8; i++) begin : g_tb_pad
      assign pins[i] = dir[i] ? 1'bz : pad_val[i];
   end

   gpio_irq #(.GPIO_ADDRESS(BASE), .WIDTH(8), .SYNC_STAGES(S)) u_dut (
      .clk(clk), .rst(rst), .din(din), .address(address), .w_en(w_en), .r_en(r_en),
      .dout(dout), .dir(dir), .port(port), .irq(irq), .pins(pins)
   );

   // narrow instance: 4 pins, 3-stage synchroniser, window ends at 8'hFF
   logic       b_rst, b_w_en, b_r_en;
   logic [7:0] b_din, b_address, b_dout;
   logic [3:0] b_dir, b_port, b_pad_val;
   logic       b_irq;
   wire  [3:0] b_pins;

   for (genvar i = 0; i < 4; i++) begin : g_tb_bpad
      assign b_pins[i] = b_dir[i] ? 1'bz : b_pad_val[i];
   end

   gpio_irq #(.GPIO_ADDRESS(BASE2), .WIDTH(4), .SYNC_STAGES(3)) u_dut_b (
      .clk(clk), .rst(b_rst), .din(b_din), .address(b_address), .w_en(b_w_en), .r_en(b_r_en),
      .dout(b_dout), .dir(b_dir), .port(b_port), .irq(b_irq), .pins(b_pins)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model and scoreboard ----------------
   typedef struct packed {
      logic [7:0] dout;
      logic       irq;
      logic [7:0] dir;
      logic [7:0] port;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] m_dir, m_port, m_ren, m_fen, m_flag;
   logic [7:0] hist [S+1];   // hist[k]: pad value sampled k+1 edges ago

   always @(posedge clk) begin
      int         off;
      logic [7:0] pad, sync, prev, rd, w1c;
      exp_t       e;
      if (rst) begin
         m_dir = 0; m_port = 0; m_ren = 0; m_fen = 0; m_flag = 0;
         for (int j = 0; j <= int'(S); j++) hist[j] = 8'h00;
         e = '0;
      end else begin
         pad  = (m_dir & m_port) | (~m_dir & pad_val);
         sync = hist[S-1];
         prev = hist[S];
         off  = int'(address) - int'(BASE);
         rd   = 8'h00;
         if (r_en) begin
            case (off)
               0: rd = m_dir;
               1: rd = m_port;
               2: rd = sync;
               6: rd = m_ren;
               7: rd = m_fen;
               8: rd = m_flag;
               default: rd = 8'h00;
            endcase
         end
         w1c    = (w_en && off == 8) ? din : 8'h00;
         m_flag = (m_flag & ~w1c) | (sync & ~prev & m_ren) | (~sync & prev & m_fen);
         if (w_en) begin
            case (off)
               0: m_dir  = din;
               1: m_port = din;
               3: m_port = m_port | din;
               4: m_port = m_port & ~din;
               5: m_port = m_port ^ din;
               6: m_ren  = din;
               7: m_fen  = din;
               default: ;
            endcase
         end
         for (int j = int'(S); j > 0; j--) hist[j] = hist[j-1];
         hist[0] = pad;
         e.dout = rd;
         e.irq  = |m_flag;
         e.dir  = m_dir;
         e.port = m_port;
      end
      exp_q.push_back(e);
   end

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("dout", 32'(dout), 32'(e.dout));
         chk("irq",  32'(irq),  32'(e.irq));
         chk("dir",  32'(dir),  32'(e.dir));
         chk("port", 32'(port), 32'(e.port));
         chk("pins_out", 32'(pins & dir), 32'(e.port & e.dir));
      end
   end

   // ---------------- stimulus helpers (called just after a negedge) ----------------
   task automatic step(input logic we, input logic re, input logic [7:0] a, input logic [7:0] d);
      w_en = we; r_en = re; address = a; din = d;
      @(negedge clk);
      w_en = 1'b0; r_en = 1'b0;
   endtask

   task automatic wr(input int off, input logic [7:0] d);
      step(1'b1, 1'b0, 8'(int'(BASE) + off), d);
   endtask

   task automatic rd(input int off);
      step(1'b0, 1'b1, 8'(int'(BASE) + off), 8'h00);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   task automatic b_step(input logic we, input logic re, input logic [7:0] a, input logic [7:0] d);
      b_w_en = we; b_r_en = re; b_address = a; b_din = d;
      @(negedge clk);
      b_w_en = 1'b0; b_r_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; w_en = 1'b0; r_en = 1'b0; din = 8'h00; address = 8'h00; pad_val = 8'h00;
      b_rst = 1'b1; b_w_en = 1'b0; b_r_en = 1'b0; b_din = 8'h00; b_address = 8'h00;
      b_pad_val = 4'h0;
      @(negedge clk);

      // reset held with write strobes active
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(int'(BASE) + i), 8'hFF);
      rst = 1'b0;
      for (int a = 0; a < 9; a++) rd(a);

      // direction / port readback and pad drive
      wr(0, 8'hF0);
      wr(1, 8'hA5);
      rd(0);
      rd(1);
      chk("pins_hi_nibble", 32'(pins[7:4]), 32'h0000_000A);

      // atomic set / clear / toggle; write-only registers read zero
      wr(1, 8'h0F); wr(3, 8'h30); wr(4, 8'h01); wr(5, 8'hFF);
      rd(1); rd(3); rd(4); rd(5);

      // rising-edge latency on pin 0
      wr(0, 8'h00);
      wr(8, 8'hFF);
      wr(6, 8'h01);
      idle(4);
      wr(8, 8'hFF);
      pad_val = 8'h01;
      idle(2);
      chk("rise_latency_early", 32'(irq), 32'h0);
      idle(1);
      chk("rise_latency_hit", 32'(irq), 32'h1);
      rd(8);
      wr(8, 8'h01);
      chk("w1c_clears_irq", 32'(irq), 32'h0);

      // falling edge coincident with W1C: set wins
      wr(7, 8'h02);
      pad_val = 8'h03;
      idle(5);
      wr(8, 8'hFF);
      pad_val = 8'h01;
      idle(2);
      wr(8, 8'h02);
      chk("edge_beats_w1c", 32'(irq), 32'h1);
      rd(8);
      wr(7, 8'h00);
      chk("flag_sticky", 32'(irq), 32'h1);
      wr(8, 8'hFF);
      chk("flag_cleared", 32'(irq), 32'h0);

      // randomized traffic including out-of-window addresses and reset pulses
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 9) == 0) pad_val = pad_val ^ 8'($urandom);
         rst = ($urandom_range(0, 199) == 0);
         step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
              8'(int'(BASE) - 1 + int'($urandom_range(0, 10))), 8'($urandom));
      end
      rst = 1'b0;
      idle(3);

      // narrow instance at the top of the address space
      b_rst = 1'b0;
      chk("b_reset_dout", 32'(b_dout), 32'h0);
      chk("b_reset_irq", 32'(b_irq), 32'h0);
      chk("b_reset_dir", 32'(b_dir), 32'h0);
      b_step(1'b1, 1'b0, BASE2, 8'hFF);
      chk("b_dir_masked", 32'(b_dir), 32'hF);
      b_step(1'b0, 1'b1, BASE2, 8'h00);
      chk("b_dir_read", 32'(b_dout), 32'h0F);
      b_step(1'b1, 1'b0, 8'(int'(BASE2) + 1), 8'hFF);
      chk("b_pins_driven", 32'(b_pins), 32'hF);
      b_step(1'b0, 1'b1, 8'h00, 8'h00);
      chk("b_read_wrapped_addr", 32'(b_dout), 32'h0);
      b_step(1'b0, 1'b1, 8'(int'(BASE2) - 1), 8'h00);
      chk("b_read_below_base", 32'(b_dout), 32'h0);
      b_step(1'b1, 1'b0, 8'(int'(BASE2) + 7), 8'hFF);
      b_step(1'b0, 1'b1, 8'(int'(BASE2) + 7), 8'h00);
      chk("b_fall_en_read", 32'(b_dout), 32'h0F);
      b_step(1'b1, 1'b0, 8'(int'(BASE2) + 5), 8'hFF);
      for (int i = 0; i < 6; i++) b_step(1'b0, 1'b0, 8'h00, 8'h00);
      chk("b_irq_fall", 32'(b_irq), 32'h1);
      b_step(1'b0, 1'b1, 8'hFF, 8'h00);
      chk("b_flag_read", 32'(b_dout), 32'h0F);
      b_step(1'b1, 1'b0, 8'hFF, 8'hFF);
      chk("b_flag_w1c", 32'(b_irq), 32'h0);

      idle(2);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
